// File: rtl/alu_muldiv_sequencer.sv
// Iterative unsigned MUL / DIVU / REMU sequencer that borrows the shared EX-stage ALU.
// It performs one ALU operation per granted cycle and holds operands and result in local registers.
module alu_muldiv_sequencer #(
  parameter int         WIDTH  = 64,
  parameter int         CNT_W  = 7,
  parameter logic [3:0] OP_ADD = 4'b0010,
  parameter logic [3:0] OP_SUB = 4'b0110,
  parameter logic [3:0] OP_BLT = 4'b1000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             alu_grant_i,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             alu_req_o,
  output logic [3:0]       alu_op_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV_CMP, S_DIV_SUB, S_DONE} state_e;

  state_e           state_q, state_d;
  // Shared working registers: r = acc / partial remainder, q = multiplicand / quotient,
  // d = multiplier / divisor.
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_rem_q, is_rem_d;

  logic [WIDTH-1:0] rs, q_sh0, q_sh1;
  logic             carry, last, start_div;

  assign rs        = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign carry     = r_q[WIDTH-1];
  assign q_sh0     = {q_q[WIDTH-2:0], 1'b0};
  assign q_sh1     = {q_q[WIDTH-2:0], 1'b1};
  assign last      = (cnt_q == CNT_W'(1));
  assign start_div = (op_i == 2'b01) || (op_i == 2'b10);

  assign busy_o   = (state_q == S_MUL) || (state_q == S_DIV_CMP) || (state_q == S_DIV_SUB);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

  always_comb begin
    alu_req_o = 1'b0;
    alu_op_o  = OP_ADD;
    alu_a_o   = '0;
    alu_b_o   = '0;
    case (state_q)
      S_MUL: begin
        alu_req_o = 1'b1;
        alu_a_o   = r_q;
        alu_b_o   = d_q[0] ? q_q : '0;
      end
      S_DIV_CMP: begin
        alu_req_o = 1'b1;
        if (!carry) begin
          alu_op_o = OP_BLT;
          alu_a_o  = rs;
          alu_b_o  = d_q;
        end
      end
      S_DIV_SUB: begin
        alu_req_o = 1'b1;
        alu_op_o  = OP_SUB;
        alu_a_o   = rs;
        alu_b_o   = d_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    is_rem_d = is_rem_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start_i) begin
          is_rem_d = (op_i == 2'b10);
          cnt_d    = CNT_W'(WIDTH);
          r_d      = '0;
          q_d      = a_i;
          d_d      = b_i;
          if (!start_div) begin
            state_d = S_MUL;
          end else if (b_i == '0) begin
            // Divide by zero resolves immediately without touching the ALU.
            result_d = (op_i == 2'b10) ? a_i : '1;
            state_d  = S_DONE;
          end else begin
            state_d = S_DIV_CMP;
          end
        end
      end
      S_MUL: begin
        if (alu_grant_i) begin
          r_d   = alu_result_i;
          q_d   = q_q << 1;
          d_d   = d_q >> 1;
          cnt_d = cnt_q - CNT_W'(1);
          if (last) begin
            result_d = alu_result_i;
            state_d  = S_DONE;
          end
        end
      end
      S_DIV_CMP: begin
        if (alu_grant_i) begin
          if (carry) begin
            state_d = S_DIV_SUB;
          end else if (alu_result_i[0]) begin
            r_d   = rs;
            q_d   = q_sh0;
            cnt_d = cnt_q - CNT_W'(1);
            if (last) begin
              result_d = is_rem_q ? rs : q_sh0;
              state_d  = S_DONE;
            end
          end else begin
            state_d = S_DIV_SUB;
          end
        end
      end
      S_DIV_SUB: begin
        if (alu_grant_i) begin
          r_d   = alu_result_i;
          q_d   = q_sh1;
          cnt_d = cnt_q - CNT_W'(1);
          if (last) begin
            result_d = is_rem_q ? alu_result_i : q_sh1;
            state_d  = S_DONE;
          end else begin
            state_d = S_DIV_CMP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A pipeline kill wins over start and grant, and must not disturb the last result.
    if (flush_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      q_q      <= q_d;
      d_q      <= d_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      is_rem_q <= is_rem_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Bench for alu_muldiv_sequencer: models the shared ALU, applies a directed vector table,
// hand-written stall/flush/reset sequences, and random operations checked against plain arithmetic.
module tb_alu_muldiv_sequencer;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_BLT = 4'b1000;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [63:0] a_i = '0;
  logic [63:0] b_i = '0;
  logic        flush_i = 1'b0;
  logic        alu_grant_i = 1'b0;
  logic [63:0] alu_result_i;
  logic        alu_req_o;
  logic [3:0]  alu_op_o;
  logic [63:0] alu_a_o, alu_b_o;
  logic        busy_o, done_o;
  logic [63:0] result_o;

  int passed = 0;
  int total  = 0;

  alu_muldiv_sequencer dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .alu_grant_i(alu_grant_i),
    .alu_result_i(alu_result_i), .alu_req_o(alu_req_o), .alu_op_o(alu_op_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  // Shared EX-stage ALU
  always_comb begin
    case (alu_op_o)
      OP_ADD:  alu_result_i = alu_a_o + alu_b_o;
      OP_SUB:  alu_result_i = alu_a_o - alu_b_o;
      OP_BLT:  alu_result_i = {63'd0, (alu_a_o < alu_b_o)};
      default: alu_result_i = '0;
    endcase
  end

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_res;
    int          exp_gnt;
  } vec_t;

  vec_t vt[10];

  function automatic logic [63:0] model_res(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op == 2'b01) return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
    if (op == 2'b10) return (b == 0) ? a : a % b;
    return a * b;
  endfunction

  // Each quotient 1-bit costs a compare plus a subtract; each 0-bit costs one compare.
  function automatic int model_gnt(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op == 2'b01 || op == 2'b10) begin
      if (b == 0) return 0;
      return 64 + $countones(a / b);
    end
    return 64;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int gpct, input int stall_at, input int stall_len,
                        output logic [63:0] res, output int busy_cnt, output int gnt_cnt,
                        output logic req_ok, output logic frozen_ok, output logic got_done);
    logic [3:0]  fo;
    logic [63:0] fa, fb;
    logic        g;
    fo = '0; fa = '0; fb = '0;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    tick();
    start_i = 1'b0;
    res = '0; busy_cnt = 0; gnt_cnt = 0;
    req_ok = 1'b1; frozen_ok = 1'b1; got_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (alu_req_o !== busy_o) req_ok = 1'b0;
      if (done_o === 1'b1) begin
        got_done = 1'b1;
        res = result_o;
        break;
      end
      if (busy_o === 1'b1) begin
        if (busy_cnt == stall_at) begin
          fo = alu_op_o; fa = alu_a_o; fb = alu_b_o;
        end else if (busy_cnt > stall_at && busy_cnt <= stall_at + stall_len) begin
          if (fo !== alu_op_o || fa !== alu_a_o || fb !== alu_b_o) frozen_ok = 1'b0;
        end
        if (busy_cnt >= stall_at && busy_cnt < stall_at + stall_len) g = 1'b0;
        else g = ($urandom_range(99) < gpct);
        alu_grant_i = g;
        busy_cnt++;
        if (g) gnt_cnt++;
      end
      tick();
    end
  endtask

  task automatic check_after_done(input string tag, input logic [63:0] exp_res);
    tick();
    chk({tag, "_idle_after_done"}, {62'd0, busy_o, done_o}, 64'd0);
    chk({tag, "_result_held"}, result_o, exp_res);
  endtask

  logic [63:0] res, e_res;
  int          bc, gc, e_gnt;
  logic        rok, fok, dn, seen_done;
  logic [1:0]  rop;
  logic [63:0] ra, rb;

  initial begin
    vt[0] = '{2'd0, 64'd7, 64'd6, 64'd42, 64};
    vt[1] = '{2'd0, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 64};
    vt[2] = '{2'd1, 64'd100, 64'd7, 64'd14, 67};
    vt[3] = '{2'd2, 64'd100, 64'd7, 64'd2, 67};
    vt[4] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1, 65};
    vt[5] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 65};
    vt[6] = '{2'd1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vt[7] = '{2'd2, 64'd5, 64'd0, 64'd5, 0};
    vt[8] = '{2'd3, 64'd3, 64'd5, 64'd15, 64};
    vt[9] = '{2'd1, 64'd0, 64'd9, 64'd0, 64};

    // Reset state
    tick(); tick();
    chk("rst_busy_done", {62'd0, busy_o, done_o}, 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_alu_req", {63'd0, alu_req_o}, 64'd0);
    chk("rst_alu_op", {60'd0, alu_op_o}, {60'd0, OP_ADD});
    chk("rst_alu_ab", alu_a_o | alu_b_o, 64'd0);
    #2 reset_i = 1'b0;
    tick();
    chk("post_rst_idle", {62'd0, busy_o, done_o}, 64'd0);

    // Directed table with permanent grant
    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, 100, -1, 0, res, bc, gc, rok, fok, dn);
      chk($sformatf("vec%0d_done", i), {63'd0, dn}, 64'd1);
      chk($sformatf("vec%0d_result", i), res, vt[i].exp_res);
      chk($sformatf("vec%0d_granted", i), 64'(gc), 64'(vt[i].exp_gnt));
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(vt[i].exp_gnt));
      chk($sformatf("vec%0d_req_eq_busy", i), {63'd0, rok}, 64'd1);
      check_after_done($sformatf("vec%0d", i), vt[i].exp_res);
    end

    // Start accepted in DONE: back-to-back operations
    run_op(2'd0, 64'd9, 64'd9, 100, -1, 0, res, bc, gc, rok, fok, dn);
    chk("b2b_first", res, 64'd81);
    run_op(2'd1, 64'd100, 64'd7, 100, -1, 0, res, bc, gc, rok, fok, dn);
    chk("b2b_second", res, 64'd14);
    chk("b2b_granted", 64'(gc), 64'd67);
    check_after_done("b2b", 64'd14);

    // Grant withheld for 10 cycles mid-MUL
    run_op(2'd0, 64'd7, 64'd6, 100, 20, 10, res, bc, gc, rok, fok, dn);
    chk("stall_result", res, 64'd42);
    chk("stall_busy_cycles", 64'(bc), 64'd74);
    chk("stall_frozen", {63'd0, fok}, 64'd1);
    check_after_done("stall", 64'd42);

    // Flush at busy cycle 20 of a DIVU
    alu_grant_i = 1'b1;
    start_i = 1'b1; op_i = 2'b01; a_i = 64'd100; b_i = 64'd7;
    tick();
    start_i = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    chk("flush_pre_busy", {63'd0, busy_o}, 64'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_idle", {62'd0, busy_o, done_o}, 64'd0);
    chk("flush_result_kept", result_o, 64'd42);
    seen_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done_o !== 1'b0 || busy_o !== 1'b0) seen_done = 1'b1;
      tick();
    end
    chk("flush_no_done", {63'd0, seen_done}, 64'd0);

    // Asynchronous reset mid-MUL
    start_i = 1'b1; op_i = 2'b00; a_i = 64'd7; b_i = 64'd6;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2 reset_i = 1'b1;
    #1;
    chk("arst_busy_done", {62'd0, busy_o, done_o}, 64'd0);
    chk("arst_result", result_o, 64'd0);
    chk("arst_alu", {alu_req_o, 59'd0, alu_op_o}, {60'd0, OP_ADD});
    chk("arst_alu_ab", alu_a_o | alu_b_o, 64'd0);
    #3 reset_i = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done_o !== 1'b0 || busy_o !== 1'b0) seen_done = 1'b1;
    end
    chk("arst_no_done", {63'd0, seen_done}, 64'd0);

    // Random operations against the arithmetic model, random grant
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(3));
      ra  = {$urandom, $urandom};
      if ($urandom_range(3) == 0) ra = 64'($urandom_range(5000));
      case ($urandom_range(4))
        0:       rb = 64'd0;
        1:       rb = 64'($urandom_range(1000, 1));
        2:       rb = {32'd0, $urandom};
        default: rb = {$urandom, $urandom};
      endcase
      e_res = model_res(rop, ra, rb);
      e_gnt = model_gnt(rop, ra, rb);
      run_op(rop, ra, rb, 70, -1, 0, res, bc, gc, rok, fok, dn);
      chk($sformatf("rnd%0d_op%0d_done", n, rop), {63'd0, dn}, 64'd1);
      chk($sformatf("rnd%0d_op%0d_result", n, rop), res, e_res);
      chk($sformatf("rnd%0d_op%0d_granted", n, rop), 64'(gc), 64'(e_gnt));
      chk($sformatf("rnd%0d_req_eq_busy", n), {63'd0, rok}, 64'd1);
      if ($urandom_range(1) == 0) check_after_done($sformatf("rnd%0d", n), e_res);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
